// File: rtl/drive_sched_pkg.sv
// Shared definitions for the drive update scheduler: FSM states, grant
// encoding, DAC word width, default drive values and the clamp helper.
package drive_sched_pkg;

  localparam int DAC_W  = 16;
  localparam int GAP_W  = 16;
  localparam int WAIT_W = 24;

  // Default values shared with the driver controller
  localparam logic [DAC_W-1:0] DEF_RESET_CURRENT = 16'h3FF0;
  localparam logic [DAC_W-1:0] DEF_RESET_LIMIT   = 16'h5FFF;
  localparam logic [DAC_W-1:0] DEF_MAX_CURRENT   = 16'h5FFF;
  localparam logic [DAC_W-1:0] DEF_SAFE_CURRENT  = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_WIN = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_GAP      = 2'd3
  } sched_state_e;

  typedef enum logic {
    GNT_HOST = 1'b0,
    GNT_SAFE = 1'b1
  } grant_e;

  // Unsigned minimum of two DAC words
  function automatic logic [DAC_W-1:0] min_dac(input logic [DAC_W-1:0] a,
                                               input logic [DAC_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/upd_gap_timer.sv
// Loadable down-counter that spaces consecutive DAC updates. It stops at
// zero and reports done while the count is zero.
module upd_gap_timer
  import drive_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  output logic             done
);

  logic [GAP_W-1:0] cnt_q;
  logic [GAP_W-1:0] cnt_d;

  // Next count: load takes priority, otherwise count down to zero and hold
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {GAP_W{1'b0}}) begin
      cnt_d = cnt_q - {{(GAP_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= {GAP_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == {GAP_W{1'b0}});

endmodule

// File: rtl/drive_update_scheduler.sv
// Arbitrates host and safety writes into the laser driver DAC path.
// Safety preempts host, host writes wait for a window outside the drive
// period and are clamped, and updates are spaced by a gap so one DAC SPI
// frame finishes before the next one is issued.
module drive_update_scheduler
  import drive_sched_pkg::*;
#(
  parameter logic [DAC_W-1:0]  RESET_CURRENT = DEF_RESET_CURRENT,
  parameter logic [DAC_W-1:0]  RESET_LIMIT   = DEF_RESET_LIMIT,
  parameter logic [DAC_W-1:0]  MAX_CURRENT   = DEF_MAX_CURRENT,
  parameter logic [DAC_W-1:0]  SAFE_CURRENT  = DEF_SAFE_CURRENT,
  parameter int                UPDATE_GAP    = 64,
  parameter logic [WAIT_W-1:0] HOST_TIMEOUT  = 24'hFFFFFF
)(
  input  logic        clk,
  input  logic        rstn,
  input  logic        host_req,
  input  logic [15:0] host_current,
  input  logic [15:0] host_limit,
  output logic        host_ack,
  input  logic        safe_req,
  output logic        safe_ack,
  input  logic        safe_clear,
  input  logic        period_active,
  input  logic        clear_flags,
  output logic [15:0] drive_current,
  output logic [15:0] drive_current_limit,
  output logic        drive_current_update,
  output logic        busy,
  output logic        safe_latched,
  output logic        host_timeout,
  output logic        clamp_flag
);

  localparam logic [GAP_W-1:0] GAP_LOAD = 16'(UPDATE_GAP - 1);

  sched_state_e      state_q, state_d;
  grant_e            grant_q, grant_d;
  logic [DAC_W-1:0]  cur_lat_q, cur_lat_d;
  logic [DAC_W-1:0]  lim_lat_q, lim_lat_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [DAC_W-1:0]  drive_current_q, drive_current_d;
  logic [DAC_W-1:0]  drive_current_limit_q, drive_current_limit_d;
  logic              update_q, update_d;
  logic              host_ack_q, host_ack_d;
  logic              safe_ack_q, safe_ack_d;
  logic              busy_q, busy_d;
  logic              safe_latched_q, safe_latched_d;
  logic              host_timeout_q, host_timeout_d;
  logic              clamp_flag_q, clamp_flag_d;

  logic              gap_load_s;
  logic              gap_done_s;
  logic              clamp_set_s;
  logic              timeout_set_s;
  logic [DAC_W-1:0]  host_lim_clamped_s;
  logic [DAC_W-1:0]  host_cur_clamped_s;
  logic              host_clamped_s;

  // Host values are limited to the ceiling, and current never exceeds limit
  always_comb begin
    host_lim_clamped_s = min_dac(host_limit, MAX_CURRENT);
    host_cur_clamped_s = min_dac(min_dac(host_current, MAX_CURRENT), host_lim_clamped_s);
    host_clamped_s     = (host_lim_clamped_s != host_limit) ||
                         (host_cur_clamped_s != host_current);
  end

  // Next-state and output computation for the scheduler FSM
  always_comb begin
    state_d               = state_q;
    grant_d               = grant_q;
    cur_lat_d             = cur_lat_q;
    lim_lat_d             = lim_lat_q;
    wait_cnt_d            = wait_cnt_q;
    drive_current_d       = drive_current_q;
    drive_current_limit_d = drive_current_limit_q;
    update_d              = 1'b0;
    host_ack_d            = 1'b0;
    safe_ack_d            = 1'b0;
    gap_load_s            = 1'b0;
    clamp_set_s           = 1'b0;
    timeout_set_s         = 1'b0;

    // A safety commit below overrides the release
    if (safe_clear) begin
      safe_latched_d = 1'b0;
    end else begin
      safe_latched_d = safe_latched_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (safe_req) begin
          cur_lat_d = SAFE_CURRENT;
          lim_lat_d = drive_current_limit_q;
          grant_d   = GNT_SAFE;
          state_d   = ST_COMMIT;
        end else if (host_req && !safe_latched_q) begin
          cur_lat_d   = host_cur_clamped_s;
          lim_lat_d   = host_lim_clamped_s;
          grant_d     = GNT_HOST;
          wait_cnt_d  = {WAIT_W{1'b0}};
          clamp_set_s = host_clamped_s;
          state_d     = ST_WAIT_WIN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_WIN: begin
        if (safe_req) begin
          // Host stays pending; it is re-granted once back in IDLE
          cur_lat_d = SAFE_CURRENT;
          lim_lat_d = drive_current_limit_q;
          grant_d   = GNT_SAFE;
          state_d   = ST_COMMIT;
        end else if (!host_req) begin
          state_d = ST_IDLE;
        end else if (!period_active) begin
          state_d = ST_COMMIT;
        end else if (wait_cnt_q == HOST_TIMEOUT) begin
          timeout_set_s = 1'b1;
        end else begin
          wait_cnt_d    = wait_cnt_q + 24'd1;
          timeout_set_s = ((wait_cnt_q + 24'd1) == HOST_TIMEOUT);
        end
      end
      ST_COMMIT: begin
        drive_current_d       = cur_lat_q;
        drive_current_limit_d = lim_lat_q;
        update_d              = 1'b1;
        gap_load_s            = 1'b1;
        state_d               = ST_GAP;
        if (grant_q == GNT_SAFE) begin
          safe_ack_d     = 1'b1;
          safe_latched_d = 1'b1;
        end else begin
          host_ack_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Sticky flags: a set in the same cycle as clear_flags wins
    clamp_flag_d   = clamp_set_s   | (clamp_flag_q   & ~clear_flags);
    host_timeout_d = timeout_set_s | (host_timeout_q & ~clear_flags);
    busy_d         = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q               <= ST_IDLE;
      grant_q               <= GNT_HOST;
      cur_lat_q             <= RESET_CURRENT;
      lim_lat_q             <= RESET_LIMIT;
      wait_cnt_q            <= {WAIT_W{1'b0}};
      drive_current_q       <= RESET_CURRENT;
      drive_current_limit_q <= RESET_LIMIT;
      update_q              <= 1'b0;
      host_ack_q            <= 1'b0;
      safe_ack_q            <= 1'b0;
      busy_q                <= 1'b0;
      safe_latched_q        <= 1'b0;
      host_timeout_q        <= 1'b0;
      clamp_flag_q          <= 1'b0;
    end else begin
      state_q               <= state_d;
      grant_q               <= grant_d;
      cur_lat_q             <= cur_lat_d;
      lim_lat_q             <= lim_lat_d;
      wait_cnt_q            <= wait_cnt_d;
      drive_current_q       <= drive_current_d;
      drive_current_limit_q <= drive_current_limit_d;
      update_q              <= update_d;
      host_ack_q            <= host_ack_d;
      safe_ack_q            <= safe_ack_d;
      busy_q                <= busy_d;
      safe_latched_q        <= safe_latched_d;
      host_timeout_q        <= host_timeout_d;
      clamp_flag_q          <= clamp_flag_d;
    end
  end

  upd_gap_timer u_gap_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (gap_load_s),
    .load_val (GAP_LOAD),
    .done     (gap_done_s)
  );

  assign drive_current        = drive_current_q;
  assign drive_current_limit  = drive_current_limit_q;
  assign drive_current_update = update_q;
  assign host_ack             = host_ack_q;
  assign safe_ack             = safe_ack_q;
  assign busy                 = busy_q;
  assign safe_latched         = safe_latched_q;
  assign host_timeout         = host_timeout_q;
  assign clamp_flag           = clamp_flag_q;

endmodule

// File: tb/tb_drive_update_scheduler.sv
// Directed bench for drive_update_scheduler with hand-computed expectations.
module tb_drive_update_scheduler;

  logic        clk = 1'b0;
  logic        rstn;
  logic        host_req;
  logic [15:0] host_current;
  logic [15:0] host_limit;
  logic        host_ack;
  logic        safe_req;
  logic        safe_ack;
  logic        safe_clear;
  logic        period_active;
  logic        clear_flags;
  logic [15:0] drive_current;
  logic [15:0] drive_current_limit;
  logic        drive_current_update;
  logic        busy;
  logic        safe_latched;
  logic        host_timeout;
  logic        clamp_flag;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int upd_cnt  = 0;
  int hack_cnt = 0;
  int sack_cnt = 0;

  drive_update_scheduler dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .host_req             (host_req),
    .host_current         (host_current),
    .host_limit           (host_limit),
    .host_ack             (host_ack),
    .safe_req             (safe_req),
    .safe_ack             (safe_ack),
    .safe_clear           (safe_clear),
    .period_active        (period_active),
    .clear_flags          (clear_flags),
    .drive_current        (drive_current),
    .drive_current_limit  (drive_current_limit),
    .drive_current_update (drive_current_update),
    .busy                 (busy),
    .safe_latched         (safe_latched),
    .host_timeout         (host_timeout),
    .clamp_flag           (clamp_flag)
  );

  // 25 MHz clock
  always #20 clk = ~clk;

  // Edge counter
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse counters sampled on the inactive edge
  always @(negedge clk) begin
    if (drive_current_update === 1'b1) upd_cnt = upd_cnt + 1;
    if (host_ack === 1'b1) hack_cnt = hack_cnt + 1;
    if (safe_ack === 1'b1) sack_cnt = sack_cnt + 1;
  end

  // Global time limit
  initial begin
    #(40 * 20000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_upd(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (drive_current_update === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      tick();
      if (busy === 1'b0) ok = 1'b1;
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL idle_wait: busy=%b required 0 within %0d cycles", busy, max_cyc);
    end
  endtask

  task automatic pulse_safe_clear();
    safe_clear = 1'b1;
    tick();
    safe_clear = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    host_req = 1'b0; host_current = 16'h0000; host_limit = 16'h0000;
    safe_req = 1'b0; safe_clear = 1'b0; period_active = 1'b0; clear_flags = 1'b0;
    repeat (3) tick();
    checks++;
    if (drive_current !== 16'h3FF0) begin
      failures++; $display("FAIL reset_current: got %h want 3ff0", drive_current);
    end
    checks++;
    if (drive_current_limit !== 16'h5FFF) begin
      failures++; $display("FAIL reset_limit: got %h want 5fff", drive_current_limit);
    end
    checks++;
    if ({drive_current_update, host_ack, safe_ack, busy, safe_latched, host_timeout, clamp_flag} !== 7'b0) begin
      failures++;
      $display("FAIL reset_status: got %b want 0000000",
               {drive_current_update, host_ack, safe_ack, busy, safe_latched, host_timeout, clamp_flag});
    end
    rstn = 1'b1;
    repeat (10) tick();
    checks++;
    if (upd_cnt !== 0) begin
      failures++; $display("FAIL reset_no_update: pulses=%0d want 0", upd_cnt);
    end
  endtask

  task automatic test_host_write();
    bit seen;
    host_current = 16'h2000; host_limit = 16'h4000; period_active = 1'b0; host_req = 1'b1;
    wait_upd(10, seen);
    host_req = 1'b0;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h2000 || drive_current_limit !== 16'h4000) begin
      failures++;
      $display("FAIL host_write_values: seen=%b cur=%h lim=%h want 1 2000 4000", seen, drive_current, drive_current_limit);
    end
    checks++;
    if ({host_ack, safe_ack} !== 2'b10) begin
      failures++; $display("FAIL host_write_ack: host/safe=%b want 10", {host_ack, safe_ack});
    end
    tick();
    checks++;
    if ({drive_current_update, host_ack, busy} !== 3'b001) begin
      failures++; $display("FAIL host_write_single_pulse: upd/ack/busy=%b want 001", {drive_current_update, host_ack, busy});
    end
    checks++;
    if (clamp_flag !== 1'b0) begin
      failures++; $display("FAIL host_write_no_clamp: clamp_flag=%b want 0", clamp_flag);
    end
    wait_idle(100);
  endtask

  task automatic test_period_window();
    bit seen;
    int n0;
    period_active = 1'b1; host_current = 16'h1234; host_limit = 16'h3000; host_req = 1'b1;
    n0 = upd_cnt;
    repeat (500) tick();
    checks++;
    if (upd_cnt !== n0 || busy !== 1'b1) begin
      failures++; $display("FAIL period_hold: pulses=%0d busy=%b want %0d 1", upd_cnt - n0, busy, 0);
    end
    period_active = 1'b0;
    wait_upd(5, seen);
    host_req = 1'b0;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h1234 || drive_current_limit !== 16'h3000) begin
      failures++;
      $display("FAIL period_release: seen=%b cur=%h lim=%h want 1 1234 3000", seen, drive_current, drive_current_limit);
    end
    checks++;
    if (host_timeout !== 1'b0) begin
      failures++; $display("FAIL period_no_timeout: host_timeout=%b want 0", host_timeout);
    end
    wait_idle(100);
  endtask

  task automatic test_clamp();
    bit seen;
    host_current = 16'h7000; host_limit = 16'h6000; host_req = 1'b1;
    wait_upd(10, seen);
    host_req = 1'b0;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h5FFF || drive_current_limit !== 16'h5FFF || clamp_flag !== 1'b1) begin
      failures++;
      $display("FAIL clamp_ceiling: seen=%b cur=%h lim=%h flag=%b want 1 5fff 5fff 1",
               seen, drive_current, drive_current_limit, clamp_flag);
    end
    wait_idle(100);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    checks++;
    if (clamp_flag !== 1'b0) begin
      failures++; $display("FAIL clamp_clear: clamp_flag=%b want 0", clamp_flag);
    end
    host_current = 16'h5000; host_limit = 16'h4000; host_req = 1'b1;
    wait_upd(10, seen);
    host_req = 1'b0;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h4000 || drive_current_limit !== 16'h4000 || clamp_flag !== 1'b1) begin
      failures++;
      $display("FAIL clamp_to_limit: seen=%b cur=%h lim=%h flag=%b want 1 4000 4000 1",
               seen, drive_current, drive_current_limit, clamp_flag);
    end
    wait_idle(100);
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    checks++;
    if (clamp_flag !== 1'b0 || drive_current !== 16'h4000) begin
      failures++; $display("FAIL clamp_clear2: flag=%b cur=%h want 0 4000", clamp_flag, drive_current);
    end
  endtask

  task automatic test_safety_priority();
    bit seen;
    int t_safe;
    int n_h;
    period_active = 1'b1; host_current = 16'h1111; host_limit = 16'h2222;
    host_req = 1'b1; safe_req = 1'b1;
    wait_upd(3, seen);
    safe_req = 1'b0;
    t_safe = cyc;
    n_h = hack_cnt;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h0000 || drive_current_limit !== 16'h4000) begin
      failures++;
      $display("FAIL safety_first: seen=%b cur=%h lim=%h want 1 0000 4000", seen, drive_current, drive_current_limit);
    end
    checks++;
    if ({safe_ack, host_ack, safe_latched} !== 3'b101) begin
      failures++; $display("FAIL safety_ack: safe/host/latched=%b want 101", {safe_ack, host_ack, safe_latched});
    end
    period_active = 1'b0;
    repeat (150) tick();
    checks++;
    if (hack_cnt !== n_h || busy !== 1'b0 || safe_latched !== 1'b1) begin
      failures++;
      $display("FAIL safety_blocks_host: acks=%0d busy=%b latched=%b want 0 0 1", hack_cnt - n_h, busy, safe_latched);
    end
    pulse_safe_clear();
    checks++;
    if (safe_latched !== 1'b0) begin
      failures++; $display("FAIL safety_clear: safe_latched=%b want 0", safe_latched);
    end
    wait_upd(10, seen);
    host_req = 1'b0;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h1111 || drive_current_limit !== 16'h2222 ||
        host_ack !== 1'b1 || (cyc - t_safe) < 64) begin
      failures++;
      $display("FAIL host_after_clear: seen=%b cur=%h lim=%h ack=%b gap=%0d want 1 1111 2222 1 >=64",
               seen, drive_current, drive_current_limit, host_ack, cyc - t_safe);
    end
    wait_idle(100);
  endtask

  task automatic test_safe_preempts_wait();
    bit seen;
    int n_h;
    period_active = 1'b1; host_current = 16'h0AAA; host_limit = 16'h0BBB; host_req = 1'b1;
    repeat (5) tick();
    n_h = hack_cnt;
    safe_req = 1'b1;
    wait_upd(4, seen);
    safe_req = 1'b0;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h0000 || drive_current_limit !== 16'h2222 ||
        safe_ack !== 1'b1 || host_ack !== 1'b0) begin
      failures++;
      $display("FAIL preempt_wait: seen=%b cur=%h lim=%h sack=%b hack=%b want 1 0000 2222 1 0",
               seen, drive_current, drive_current_limit, safe_ack, host_ack);
    end
    wait_idle(100);
    checks++;
    if (hack_cnt !== n_h) begin
      failures++; $display("FAIL preempt_no_host_ack: acks=%0d want 0", hack_cnt - n_h);
    end
    pulse_safe_clear();
    period_active = 1'b0;
    wait_upd(10, seen);
    host_req = 1'b0;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h0AAA || drive_current_limit !== 16'h0BBB || host_ack !== 1'b1) begin
      failures++;
      $display("FAIL preempt_host_resume: seen=%b cur=%h lim=%h ack=%b want 1 0aaa 0bbb 1",
               seen, drive_current, drive_current_limit, host_ack);
    end
    wait_idle(100);
  endtask

  task automatic test_back_to_back();
    bit seen;
    int t1;
    int t2;
    period_active = 1'b0; host_current = 16'h0100; host_limit = 16'h0200; host_req = 1'b1;
    wait_upd(10, seen);
    t1 = cyc;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h0100 || drive_current_limit !== 16'h0200) begin
      failures++;
      $display("FAIL b2b_first: seen=%b cur=%h lim=%h want 1 0100 0200", seen, drive_current, drive_current_limit);
    end
    host_current = 16'h0300; host_limit = 16'h0400;
    wait_upd(100, seen);
    t2 = cyc;
    host_req = 1'b0;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h0300 || drive_current_limit !== 16'h0400 || (t2 - t1) < 64) begin
      failures++;
      $display("FAIL b2b_second: seen=%b cur=%h lim=%h spacing=%0d want 1 0300 0400 >=64",
               seen, drive_current, drive_current_limit, t2 - t1);
    end
    safe_req = 1'b1;
    wait_upd(100, seen);
    safe_req = 1'b0;
    checks++;
    if (seen !== 1'b1 || drive_current !== 16'h0000 || drive_current_limit !== 16'h0400 ||
        safe_ack !== 1'b1 || (cyc - t2) < 64) begin
      failures++;
      $display("FAIL safety_after_gap: seen=%b cur=%h lim=%h sack=%b spacing=%0d want 1 0000 0400 1 >=64",
               seen, drive_current, drive_current_limit, safe_ack, cyc - t2);
    end
    wait_idle(100);
    pulse_safe_clear();
  endtask

  task automatic test_reset_mid();
    int n_u;
    int n_a;
    period_active = 1'b1; host_current = 16'h0123; host_limit = 16'h0456; host_req = 1'b1;
    repeat (6) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL reset_mid_busy: busy=%b want 1", busy);
    end
    n_u = upd_cnt;
    n_a = hack_cnt;
    rstn = 1'b0;
    #1;
    checks++;
    if (drive_current !== 16'h3FF0 || drive_current_limit !== 16'h5FFF || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_values: cur=%h lim=%h busy=%b want 3ff0 5fff 0", drive_current, drive_current_limit, busy);
    end
    host_req = 1'b0;
    period_active = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    repeat (10) tick();
    checks++;
    if (upd_cnt !== n_u || hack_cnt !== n_a) begin
      failures++; $display("FAIL reset_mid_no_pulse: pulses=%0d acks=%0d want 0 0", upd_cnt - n_u, hack_cnt - n_a);
    end
  endtask

  initial begin
    test_reset();
    test_host_write();
    test_period_window();
    test_clamp();
    test_safety_priority();
    test_safe_preempts_wait();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
